// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - MEM-stage data-memory responder with multi-cycle latency, response pulse and pipeline stall
module dmem_responder #(
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              stall,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [3:0]         cnt;
    logic [3:0]         cnt_next;
    logic [3:0]         acc_lat;

    logic               lat_we;
    logic [ADDR_W-1:0]  lat_addr;
    logic [31:0]        lat_wdata;

    logic               commit;
    logic               commit_we;
    logic [ADDR_W-1:0]  commit_addr;
    logic [31:0]        commit_wdata;

    logic [31:0]        mem [DEPTH];

    assign acc_lat = req_we ? WR_LAT_C : RD_LAT_C;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (acc_lat == 4'd1) begin
                        next_state = RESP;
                    end else begin
                        next_state = WAIT;
                        cnt_next   = acc_lat - 4'd2;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A single-cycle access commits straight from IDLE, before the latch holds the request.
    always_comb begin
        commit       = (next_state == RESP);
        commit_we    = (state == IDLE) ? req_we    : lat_we;
        commit_addr  = (state == IDLE) ? req_addr  : lat_addr;
        commit_wdata = (state == IDLE) ? req_wdata : lat_wdata;
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign stall     = req_valid & ~rsp_valid;

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
        end else if (state == IDLE && req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (commit && commit_we) begin
            mem[commit_addr] <= commit_wdata;
        end
    end

    // Load data is read from the pre-edge array contents.
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            rsp_rdata <= 32'd0;
        end else if (commit) begin
            rsp_rdata <= commit_we ? commit_wdata : mem[commit_addr];
        end
    end

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (commit) begin
            if (commit_we) begin
                if (wr_count != '1) wr_count <= wr_count + 1'b1;
            end else begin
                if (rd_count != '1) rd_count <= rd_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the 5-stage pipelined CPU, serving the pipeline's load/store requests.
- Holds a 32 x 32-bit register-file memory with parameterised multi-cycle read/write latency.
- Uses a valid/ready request channel and a one-cycle response pulse.
- Produces a stall signal that the pipeline ORs into its hazard stall so that MEM is held until the access completes.

Parameters:
ADDR_W, 5, word-address width; DEPTH = 2**ADDR_W words
RD_LAT, 2, cycles from read acceptance to response; legal range 1..15
WR_LAT, 1, cycles from write acceptance to response; legal range 1..15
CNT_W, 16, width of the saturating performance counters

Ports:
Clock  in  1  the only clock; all state changes on the rising edge
Resetn  in  1  reset, asynchronous and active-high
req_valid  in  1  MEM stage presents a request
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address, driven from mem_Alu_Result low bits
req_wdata  in  32  store data, driven from mem_rb
req_ready  out  1  responder can accept a request this cycle
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  32  load data, or the written data for a store; valid while rsp_valid
stall  out  1  hold pipeline: req_valid & ~rsp_valid
rd_count  out  CNT_W  completed loads, saturating
wr_count  out  CNT_W  completed stores, saturating

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (asynchronous, any state):
  - FSM returns to IDLE, latency counter clears, rsp_valid=0, rsp_rdata=0, rd_count=0, wr_count=0.
  - All memory words clear to 0.
  - Outputs after reset: req_ready=1, stall=req_valid.
  - A transaction in flight at reset is dropped. It produces no response and writes nothing.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Acceptance happens on the edge where req_valid=1. At that edge the block latches req_we, req_addr and req_wdata.
  - Let LAT = req_we ? WR_LAT : RD_LAT.
  - If LAT=1, go to RESP. Otherwise load cnt = LAT-2 and go to WAIT.
- WAIT:
  - req_ready=0.
  - cnt decrements each edge. At the edge where cnt==0, go to RESP.
- Commit edge (the edge that enters RESP):
  - Store: mem[addr] <= wdata, and rsp_rdata <= wdata.
  - Load: rsp_rdata <= mem[addr], sampled before any write on that same edge.
  - Increment wr_count or rd_count, holding at all-ones.
- RESP:
  - rsp_valid=1 for exactly one cycle, req_ready=0, then go to IDLE.
  - No request is accepted in RESP. Back-to-back requests are therefore spaced LAT+1 cycles apart.
- Latency: with acceptance at edge E0, rsp_valid is high in the cycle following edge E0+LAT-1. That is LAT cycles after the acceptance cycle.
- rsp_rdata holds its last value outside RESP.
- Latched request:
  - Changes on req_* after acceptance are ignored.
  - Dropping req_valid mid-transaction does not abort it; the response is still issued.
- stall is combinational: req_valid & ~rsp_valid.
  - It is low in the RESP cycle, so the pipeline advances on the edge that ends RESP.
  - It is low whenever req_valid=0.
- A load to an address stored by the immediately preceding transaction returns the new data, because the store committed earlier.
- Addresses are always in range, since DEPTH = 2**ADDR_W.
- Counter saturation: at all-ones, further completions leave the counter unchanged.

Test Plan:
1. Reset, then read: assert reset mid-cycle, release; load addr 3 -> rsp_rdata=0 after RD_LAT=2 cycles, rsp_valid pulses for exactly one cycle, rd_count=1.
2. Store then load: store 0xDEADBEEF to addr 5 (WR_LAT=1), then load addr 5 -> store response in the cycle after acceptance with rsp_rdata=0xDEADBEEF; load returns 0xDEADBEEF; wr_count=1, rd_count=1.
3. Stall timing: hold req_valid=1 for a load -> stall=1 for cycles 0..1, 0 in the RESP cycle; req_ready=0 from the acceptance edge until IDLE; next request accepted exactly 3 cycles after the first.
4. Ignored changes: change req_addr to 7 and drop req_valid during WAIT -> the response still arrives on schedule with mem[5] data; mem[7] untouched.
5. Reset mid-flight: store 0x1234 to addr 2 with WR_LAT=4, assert reset in WAIT -> no rsp_valid; subsequent load of addr 2 returns 0; counters are 0.
6. Saturation: with CNT_W=4, perform 17 loads -> rd_count stops at 0xF.
